// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard unit for a 5-stage RV32I pipeline (F/D/E/M/W). It generates the
// per-stage hold (stall_*) and clear (flush_*) controls, and the ALU operand
// forwarding selects. It also freezes the pipeline while a multi-cycle
// data-memory access is outstanding, and abandons that access after a timeout.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rs1_d, rs2_d             decode-stage source registers
//   rs1_e, rs2_e, rd_e       execute-stage sources / destination
//   load_e, pc_src_e         E holds a load / E resolved a taken branch
//   rd_m, reg_write_m        memory-stage destination and write enable
//   mem_req_m, mem_ready     memory-stage access active / memory response valid
//   rd_w, reg_write_w        writeback-stage destination and write enable
//   stall_f/d/e/m            hold the stage register (en = ~stall)
//   flush_d/e/w              clear the stage register
//   forward_a_e/_b_e         00 register file, 01 W result, 10 M result
//   mem_timeout              sticky flag: a memory access timed out
//   stall_cnt, flush_cnt     saturating counters: stall_f cycles, branch flushes
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic             load_e,
  input  logic             pc_src_e,
  input  logic [4:0]       rd_m,
  input  logic             reg_write_m,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  input  logic [4:0]       rd_w,
  input  logic             reg_write_w,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              WCW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {ST_RUN, ST_WAIT} state_e;

  state_e           state_q;
  logic [WCW-1:0]   wait_cnt_q;
  logic             mem_timeout_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic timeout_now;
  logic mem_stall;
  logic load_use;
  logic branch_flush;

  // M result has priority over W because it is the younger write.
  // x0 is hard-wired to zero, so it never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (reg_write_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (reg_write_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                                return 2'b00;
  endfunction

  assign forward_a_e = fwd_sel(rs1_e);
  assign forward_b_e = fwd_sel(rs2_e);

  // The timeout is qualified with mem_req_m so a request that goes away during
  // WAIT cannot raise a spurious timeout.
  assign timeout_now = (state_q == ST_WAIT) && (wait_cnt_q == WAIT_LAST)
                       && mem_req_m && !mem_ready;
  assign mem_stall   = mem_req_m && !mem_ready && !timeout_now;
  assign load_use    = load_e && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d);
  // A memory freeze holds E, so the branch in E is simply retaken after release.
  assign branch_flush = pc_src_e && !mem_stall;

  // NOTE: every output gets a default first, so each path through the priority
  // chain assigns all of them and no latch is inferred.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (pc_src_e) begin
      // A concurrent load-use is dropped: its D instruction is being flushed.
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Memory-wait FSM. mem_timeout is a registered output of this block.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_req_m && !mem_ready) begin
            state_q    <= ST_WAIT;
            wait_cnt_q <= WCW'(1);
          end
        end
        ST_WAIT: begin
          if (mem_ready || !mem_req_m) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
          end else if (timeout_now) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WCW'(1);
          end
        end
        default: begin
          state_q    <= ST_RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  // Saturating performance counters: hold at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && stall_cnt_q != '1)      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (branch_flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl with TIMEOUT_CYCLES = 4 and
// CNT_W = 4. Each cycle the expected outputs are pushed to a scoreboard as the
// stimulus is applied, then popped and compared at the falling edge.
// Counter/mem_timeout expectations are the values visible in that cycle,
// i.e. they reflect events of earlier cycles.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic          load_e, pc_src_e, reg_write_m, mem_req_m, mem_ready, reg_write_w;
  logic          stall_f, stall_d, stall_e, stall_m;
  logic          flush_d, flush_e, flush_w;
  logic [1:0]    forward_a_e, forward_b_e;
  logic          mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .load_e(load_e), .pc_src_e(pc_src_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m),
    .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .rd_w(rd_w), .reg_write_w(reg_write_w),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    string      tag;
    logic [3:0] st;   // {stall_f, stall_d, stall_e, stall_m}
    logic [2:0] fl;   // {flush_d, flush_e, flush_w}
    logic [1:0] fa;
    logic [1:0] fb;
    logic       tmo;
    int         sc;
    int         fc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0;
    rd_m = '0; rd_w = '0;
    load_e = 1'b0; pc_src_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
    mem_req_m = 1'b0; mem_ready = 1'b0;
  endtask

  // Push the expectation for the current cycle, compare at the falling edge,
  // then advance to just after the next rising edge.
  task automatic tick(input string tag, input logic [3:0] st, input logic [2:0] fl,
                      input logic [1:0] fa, input logic [1:0] fb, input logic tmo,
                      input int sc, input int fc);
    exp_t e;
    sb.push_back('{tag, st, fl, fa, fb, tmo, sc, fc});
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, ".stall"}, 32'({stall_f, stall_d, stall_e, stall_m}), 32'(e.st));
    check({e.tag, ".flush"}, 32'({flush_d, flush_e, flush_w}), 32'(e.fl));
    check({e.tag, ".fwd_a"}, 32'(forward_a_e), 32'(e.fa));
    check({e.tag, ".fwd_b"}, 32'(forward_b_e), 32'(e.fb));
    check({e.tag, ".tmo"},   32'(mem_timeout), 32'(e.tmo));
    check({e.tag, ".scnt"},  32'(stall_cnt), 32'(e.sc));
    check({e.tag, ".fcnt"},  32'(flush_cnt), 32'(e.fc));
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    tick(tag, 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    do_reset("reset");

    // Forwarding: M over W, x0 never forwards.
    rd_m = 5'd5; reg_write_m = 1'b1; rd_w = 5'd5; reg_write_w = 1'b1; rs1_e = 5'd5;
    tick("fwd_m_prio", 4'b0000, 3'b000, 2'b10, 2'b00, 1'b0, 0, 0);
    rd_m = 5'd0;
    tick("fwd_w",      4'b0000, 3'b000, 2'b01, 2'b00, 1'b0, 0, 0);
    rd_w = 5'd0;
    tick("fwd_none",   4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 0, 0);
    rd_m = 5'd9; reg_write_m = 1'b0; rd_w = 5'd9; rs2_e = 5'd9;
    tick("fwd_b_w",    4'b0000, 3'b000, 2'b00, 2'b01, 1'b0, 0, 0);
    reg_write_m = 1'b1;
    tick("fwd_b_m",    4'b0000, 3'b000, 2'b00, 2'b10, 1'b0, 0, 0);
    idle_inputs();

    // Load-use: one stall cycle, then the load sits in M and forwards.
    load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
    tick("lu_stall",   4'b1100, 3'b010, 2'b00, 2'b00, 1'b0, 0, 0);
    idle_inputs();
    rd_m = 5'd7; reg_write_m = 1'b1; rs2_e = 5'd7;
    tick("lu_release", 4'b0000, 3'b000, 2'b00, 2'b10, 1'b0, 1, 0);
    idle_inputs();
    load_e = 1'b1; rd_e = 5'd0;
    tick("lu_x0",      4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1, 0);
    rd_e = 5'd3; rs1_d = 5'd3;
    tick("lu_rs1",     4'b1100, 3'b010, 2'b00, 2'b00, 1'b0, 1, 0);

    // Taken branch overrides a concurrent load-use.
    rd_e = 5'd7; rs1_d = 5'd0; rs2_d = 5'd7; pc_src_e = 1'b1;
    tick("br_over_lu", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 2, 0);
    idle_inputs();
    tick("br_cnt",     4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 2, 1);

    // Memory wait of 3 cycles; a branch during the freeze is ignored.
    do_reset("reset_mem");
    mem_req_m = 1'b1;
    tick("mw_c1",      4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 0, 0);
    pc_src_e = 1'b1;
    tick("mw_c2_br",   4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 1, 0);
    pc_src_e = 1'b0;
    tick("mw_c3",      4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 2, 0);
    mem_ready = 1'b1;
    tick("mw_ready",   4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 3, 0);
    // Back-to-back access restarts from RUN.
    mem_ready = 1'b0;
    tick("b2b_c1",     4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 3, 0);
    mem_ready = 1'b1;
    tick("b2b_ready",  4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 4, 0);
    idle_inputs();
    tick("mw_idle",    4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 4, 0);

    // Timeout: ready never arrives; stall drops in the 4th cycle.
    do_reset("reset_tmo");
    mem_req_m = 1'b1;
    tick("to_c1",      4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 0, 0);
    tick("to_c2",      4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 1, 0);
    tick("to_c3",      4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 2, 0);
    tick("to_c4",      4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 3, 0);
    idle_inputs();
    tick("to_sticky1", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b1, 3, 0);
    tick("to_sticky2", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b1, 3, 0);
    do_reset("to_rst_clear");

    // Mid-wait reset, then a fresh wait must count again from 1.
    mem_req_m = 1'b1;
    tick("mid_c1",     4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 0, 0);
    tick("mid_c2",     4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 1, 0);
    do_reset("mid_rst");
    mem_req_m = 1'b1;
    tick("post_c1",    4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 0, 0);
    tick("post_c2",    4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 1, 0);
    tick("post_c3",    4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 2, 0);
    mem_ready = 1'b1;
    tick("post_ready", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 3, 0);

    // Saturation: 20 stalled cycles on a 4-bit counter hold at 15.
    do_reset("reset_sat");
    load_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7;
    for (int i = 0; i < 20; i++) begin
      tick($sformatf("sat_%0d", i), 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0,
           (i > 15) ? 15 : i, 0);
    end
    idle_inputs();
    tick("sat_hold1",  4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 15, 0);
    tick("sat_hold2",  4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 15, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
